// File: rtl/voice_scheduler.sv
// voice_scheduler: shares one note->divider lookup across NUM_VOICES voices
// and runs one square-wave oscillator per voice from a registered divider.
// Voices whose note/octave differs from the last value sent to the lookup
// are served round-robin, one capture per two cycles.

// Per-voice square-wave oscillator with its own divider register.
module vs_osc #(
  parameter int DIV_W = 19
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             active,
  input  logic             cap,
  input  logic [DIV_W-1:0] cap_div,
  output logic             wave
);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt;

  // Capture, enable-low and off-note all restart the oscillator from phase 0;
  // otherwise count to div_reg-1 and toggle.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      div_reg <= DIV_W'(1);
      cnt     <= '0;
      wave    <= 1'b0;
    end else begin
      if (cap) div_reg <= cap_div;
      if (cap || !en || !active) begin
        cnt  <= '0;
        wave <= 1'b0;
      end else if (cnt == div_reg - DIV_W'(1)) begin
        cnt  <= '0;
        wave <= ~wave;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

module voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int DIV_W      = 19
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    en,
  input  logic [4*NUM_VOICES-1:0] note_in,
  input  logic [3*NUM_VOICES-1:0] octave_in,
  output logic [3:0]              lut_note,
  output logic [2:0]              lut_octave,
  input  logic [DIV_W-1:0]        lut_divider,
  output logic [NUM_VOICES-1:0]   wave_out,
  output logic                    busy
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef struct packed {
    logic [3:0] note;
    logic [2:0] oct;
  } vreq_t;

  typedef enum logic {IDLE = 1'b0, LOOKUP = 1'b1} state_t;

  vreq_t [NUM_VOICES-1:0] req;
  vreq_t [NUM_VOICES-1:0] shadow;
  logic  [NUM_VOICES-1:0] pending;
  logic  [NUM_VOICES-1:0] active;
  logic  [NUM_VOICES-1:0] cap;
  logic  [VW-1:0]         rr_ptr;
  logic  [VW-1:0]         cur_voice;
  logic  [VW-1:0]         gnt_idx;
  logic                   gnt_vld;
  logic                   do_grant;
  logic                   do_cap;
  logic  [DIV_W-1:0]      cap_div;
  state_t                 state, state_nxt;

  // Unpack per-voice inputs, detect changes against the last sent value, and
  // decode the oscillator controls for each voice.
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_lane
    assign req[v].note = note_in[4*v +: 4];
    assign req[v].oct  = octave_in[3*v +: 3];
    assign pending[v]  = (req[v] != shadow[v]);
    assign active[v]   = (shadow[v].note >= 4'd1) && (shadow[v].note <= 4'd13);
    assign cap[v]      = do_cap && (cur_voice == VW'(v));
  end

  // First pending voice at or after ptr, wrapping.
  function automatic logic [VW:0] rr_pick(input logic [NUM_VOICES-1:0] p,
                                          input logic [VW-1:0] ptr);
    logic          found;
    logic [VW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_VOICES) j = j - NUM_VOICES;
      if (!found && p[j]) begin
        found = 1'b1;
        idx   = VW'(j);
      end
    end
    return {found, idx};
  endfunction

  // Round-robin arbiter over pending voices.
  always_comb begin
    {gnt_vld, gnt_idx} = rr_pick(pending, rr_ptr);
  end

  // A zero divider would stall the counter; clamp it to 1.
  assign cap_div = (lut_divider == '0) ? DIV_W'(1) : lut_divider;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: a grant always spends exactly one cycle in LOOKUP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: grant strobe in IDLE, capture strobe and busy in LOOKUP.
  always_comb begin
    do_grant = 1'b0;
    do_cap   = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE:    do_grant = gnt_vld;
      LOOKUP: begin
        do_cap = 1'b1;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  // Grant: latch inputs into shadow and lookup regs. Capture: advance pointer.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      shadow     <= '0;
      lut_note   <= '0;
      lut_octave <= '0;
      cur_voice  <= '0;
      rr_ptr     <= '0;
    end else begin
      if (do_grant) begin
        shadow[gnt_idx] <= req[gnt_idx];
        lut_note        <= req[gnt_idx].note;
        lut_octave      <= req[gnt_idx].oct;
        cur_voice       <= gnt_idx;
      end
      if (do_cap)
        rr_ptr <= (cur_voice == VW'(NUM_VOICES-1)) ? '0 : cur_voice + VW'(1);
    end
  end

  vs_osc #(.DIV_W(DIV_W)) u_osc [NUM_VOICES-1:0] (
    .clk     (clk),
    .nrst    (nrst),
    .en      (en),
    .active  (active),
    .cap     (cap),
    .cap_div (cap_div),
    .wave    (wave_out)
  );

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: directed scenarios with literal expectations plus
// randomized traffic, all cross-checked each cycle against an event-level model
// (waves computed from the edge of the last phase restart and the divider).
module tb_voice_scheduler;

  localparam int N  = 4;
  localparam int DW = 19;

  logic            clk = 1'b0;
  logic            nrst;
  logic            en;
  logic [4*N-1:0]  note_in;
  logic [3*N-1:0]  octave_in;
  logic [3:0]      lut_note;
  logic [2:0]      lut_octave;
  logic [DW-1:0]   lut_divider;
  logic [N-1:0]    wave_out;
  logic            busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External lookup model.
  function automatic int lut_f(int n, int o);
    if (n == 10 && o == 4) return 13636;
    if (n == 1 && o == 7)  return 2866;
    if (n == 0)            return 1;
    return (n * 7 + o * 3) % 20;
  endfunction

  assign lut_divider = DW'(lut_f(int'(lut_note), int'(lut_octave)));

  voice_scheduler #(.NUM_VOICES(N), .DIV_W(DW)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .en          (en),
    .note_in     (note_in),
    .octave_in   (octave_in),
    .lut_note    (lut_note),
    .lut_octave  (lut_octave),
    .lut_divider (lut_divider),
    .wave_out    (wave_out),
    .busy        (busy)
  );

  // ---------------- reference model ----------------
  int     m_sn[N], m_so[N], m_div[N];
  longint m_org[N];
  longint m_edge = 0;
  int     m_rr, m_cur, m_ln, m_lo, m_d, m_v;
  bit     m_busy, m_ok = 1'b0, m_found;

  always @(posedge clk) begin
    m_edge++;
    if (!nrst) begin
      m_ok = 1'b1; m_busy = 1'b0; m_rr = 0; m_cur = 0; m_ln = 0; m_lo = 0;
      for (int v = 0; v < N; v++) begin
        m_sn[v] = 0; m_so[v] = 0; m_div[v] = 1; m_org[v] = m_edge;
      end
    end else begin
      // phase restarts use the note value held before this edge
      for (int v = 0; v < N; v++)
        if (!en || m_sn[v] < 1 || m_sn[v] > 13 || (m_busy && m_cur == v))
          m_org[v] = m_edge;
      if (m_busy) begin
        m_d = lut_f(m_ln, m_lo);
        m_div[m_cur] = (m_d == 0) ? 1 : m_d;
        m_rr = (m_cur + 1) % N;
        m_busy = 1'b0;
      end else begin
        m_found = 1'b0;
        for (int i = 0; i < N; i++) begin
          m_v = (m_rr + i) % N;
          if (!m_found && (int'(note_in[4*m_v +: 4]) != m_sn[m_v] ||
                           int'(octave_in[3*m_v +: 3]) != m_so[m_v])) begin
            m_found = 1'b1;
            m_sn[m_v] = int'(note_in[4*m_v +: 4]);
            m_so[m_v] = int'(octave_in[3*m_v +: 3]);
            m_ln = m_sn[m_v]; m_lo = m_so[m_v]; m_cur = m_v; m_busy = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Advance one cycle and compare all outputs against the model.
  task automatic tick();
    logic [N-1:0] mw;
    @(negedge clk);
    if (m_ok) begin
      for (int v = 0; v < N; v++)
        mw[v] = (((m_edge - m_org[v]) / longint'(m_div[v])) % 2) == 1;
      chk("m_busy", 64'(busy), 64'(m_busy));
      chk("m_lut_note", 64'(lut_note), 64'(m_ln));
      chk("m_lut_octave", 64'(lut_octave), 64'(m_lo));
      chk("m_wave", 64'(wave_out), 64'(mw));
    end
  endtask

  task automatic setv(input int v, input int n, input int o);
    note_in[4*v +: 4]   = 4'(n);
    octave_in[3*v +: 3] = 3'(o);
  endtask

  // Count cycles until wave_out[v] reaches want, bounded by maxc.
  task automatic wait_for(input int v, input bit want, input int maxc, output int n);
    bit ok = 1'b0;
    n = 0;
    while (!ok && n < maxc) begin
      tick();
      n++;
      if (wave_out[v] === want) ok = 1'b1;
    end
    if (!ok) chk("wait_timeout", 64'(n), 64'(0));
  endtask

  initial begin
    int n1, n2, n3, g, last;
    bit flag;
    nrst = 1'b0; en = 1'b0; note_in = '0; octave_in = '0;
    tick(); tick();
    // reset state
    chk("rst_wave", 64'(wave_out), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_lut_note", 64'(lut_note), 64'(0));
    nrst = 1'b1;

    // single voice: one-cycle busy, frequency
    setv(0, 10, 4); en = 1'b1;
    tick();
    chk("t1_busy_hi", 64'(busy), 64'(1));
    chk("t1_lut_note", 64'(lut_note), 64'(10));
    chk("t1_lut_oct", 64'(lut_octave), 64'(4));
    tick();
    chk("t1_busy_lo", 64'(busy), 64'(0));
    wait_for(0, 1'b1, 20000, n1);
    chk("t1_first_rise", 64'(n1), 64'(13636));
    wait_for(0, 1'b0, 20000, n2);
    wait_for(0, 1'b1, 20000, n3);
    chk("t1_period", 64'(n2 + n3), 64'(27272));

    // all four voices at once from rr_ptr=0
    nrst = 1'b0; tick(); nrst = 1'b1;
    for (int v = 0; v < N; v++) setv(v, 2 + v, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t2_busy_seq", 64'(busy), 64'(k % 2));
      if (k % 2 == 1) chk("t2_grant_order", 64'(lut_note), 64'(2 + (k - 1) / 2));
    end
    setv(1, 6, 1); tick(); tick();
    setv(0, 7, 0); setv(3, 8, 0);
    tick();
    chk("t2_rr_v3_first", 64'(lut_note), 64'(8));
    tick(); tick();
    chk("t2_then_v0", 64'(lut_note), 64'(7));
    tick(); tick();

    // voice1 changes repeatedly while voice0 in LOOKUP
    setv(0, 2, 0); tick();
    setv(1, 5, 1);
    g = 0; last = -1;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (busy && lut_octave == 3'd1) begin g++; last = int'(lut_note); end
      if (t == 0) setv(1, 7, 1);
      if (t == 1) setv(1, 9, 1);
    end
    chk("t3_grants_1or2", 64'(g >= 1 && g <= 2), 64'(1));
    chk("t3_final_note", 64'(last), 64'(9));

    // off note on voice2 stays silent, then a real note
    setv(2, 0, 3); tick();
    chk("t4_off_lut", 64'(lut_note), 64'(0));
    tick();
    flag = 1'b0;
    for (int t = 0; t < 1000; t++) begin tick(); if (wave_out[2] !== 1'b0) flag = 1'b1; end
    chk("t4_off_silent", 64'(flag), 64'(0));
    setv(2, 1, 7); tick(); tick();
    wait_for(2, 1'b1, 5000, n1);
    chk("t4_rise", 64'(n1), 64'(2866));
    wait_for(2, 1'b0, 5000, n1);
    chk("t4_half", 64'(n1), 64'(2866));

    // enable drop mid-period and restart
    repeat (1000) tick();
    en = 1'b0; tick();
    chk("t5_en_off", 64'(wave_out), 64'(0));
    tick(); tick();
    en = 1'b1;
    wait_for(2, 1'b1, 5000, n1);
    chk("t5_restart", 64'(n1), 64'(2866));

    // reset during LOOKUP
    setv(0, 3, 2); tick();
    chk("t6_in_lookup", 64'(busy), 64'(1));
    nrst = 1'b0; tick();
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_wave", 64'(wave_out), 64'(0));
    nrst = 1'b1; tick();
    chk("t6_regrant", 64'(busy), 64'(1));
    chk("t6_regrant_note", 64'(lut_note), 64'(3));
    repeat (20) tick();

    // randomized traffic
    for (int t = 0; t < 4000; t++) begin
      nrst = 1'b1;
      if ($urandom_range(7) == 0)
        setv($urandom_range(N - 1), $urandom_range(15), $urandom_range(7));
      if ($urandom_range(49) == 0) en = ~en;
      if ($urandom_range(199) == 0) nrst = 1'b0;
      tick();
    end
    nrst = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
